// File: rtl/cache_controller_if.sv
// CPU / cache-array / main-memory signal bundle for cache_controller.
// The slave modport is the controller's view; master is the surrounding system.
interface cache_controller_if #(
    parameter int AW = 15
);
    logic          memReadReq;
    logic [AW-1:0] address;
    logic          hit;
    logic [AW-1:0] cacheAddress;
    logic          cRead;
    logic          cWrite;
    logic [AW-1:0] adr0;
    logic [AW-1:0] adr1;
    logic [AW-1:0] adr2;
    logic [AW-1:0] adr3;
    logic          ramRead;
    logic [AW-1:0] ramAddress;
    logic          ramReady;
    logic          ready;
    logic          busy;
    logic [14:0]   missCount;

    modport master (
        output memReadReq, address, hit, ramReady,
        input  cacheAddress, cRead, cWrite, adr0, adr1, adr2, adr3,
               ramRead, ramAddress, ready, busy, missCount
    );

    modport slave (
        input  memReadReq, address, hit, ramReady,
        output cacheAddress, cRead, cWrite, adr0, adr1, adr2, adr3,
               ramRead, ramAddress, ready, busy, missCount
    );
endinterface

// File: rtl/cache_controller.sv
// Read-miss cache controller: lookup, block fetch from memory, fill, re-lookup.
// Define CACHE_CTRL_MISS_CNT_EN to build the lookup-miss counter (missCount).
module cache_controller #(
    parameter int ADDRESSL = 12,
    parameter int TAG      = 3,
    parameter int BLOCKL   = 4,
    localparam int AW      = ADDRESSL + TAG,
    localparam int OFFW    = $clog2(BLOCKL)
) (
    input logic               clk,
    input logic               rst,
    cache_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOOKUP, MEM_WAIT, FILL, RELOOK, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-OFFW-1:0] blk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.memReadReq) begin
                    addr_d  = bus.address;
                    state_d = LOOKUP;
                end
            end
            LOOKUP, RELOOK: state_d = bus.hit ? DONE : MEM_WAIT;
            MEM_WAIT:       if (bus.ramReady) state_d = FILL;
            FILL:           state_d = RELOOK;
            DONE:           state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // Address outputs always reflect addrReg; only the strobes depend on state.
    assign blk              = addr_q[AW-1:OFFW];
    assign bus.cacheAddress = addr_q;
    assign bus.ramAddress   = {blk, OFFW'(0)};
    assign bus.adr0         = {blk, OFFW'(0)};
    assign bus.adr1         = {blk, OFFW'(1)};
    assign bus.adr2         = {blk, OFFW'(2)};
    assign bus.adr3         = {blk, OFFW'(3)};

    assign bus.cRead   = (state_q == LOOKUP) || (state_q == RELOOK) || (state_q == DONE);
    assign bus.cWrite  = (state_q == FILL);
    assign bus.ramRead = (state_q == MEM_WAIT);
    assign bus.ready   = (state_q == DONE);
    assign bus.busy    = (state_q != IDLE);

`ifdef CACHE_CTRL_MISS_CNT_EN
    logic [14:0] miss_q, miss_d;

    // Only the first lookup of a request counts; RELOOK retries do not.
    always_comb begin
        miss_d = miss_q;
        if (state_q == LOOKUP && !bus.hit) miss_d = miss_q + 15'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) miss_q <= '0;
        else     miss_q <= miss_d;
    end

    assign bus.missCount = miss_q;
`else
    assign bus.missCount = '0;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hit, miss, retry, wrap, reset abort, busy ignore.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cache_controller;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_miss = 0;

    always #5 clk = ~clk;

    cache_controller_if #(.AW(AW)) bus();

    cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic count_miss;
`ifdef CACHE_CTRL_MISS_CNT_EN
        exp_miss++;
`endif
    endtask

    // One missing request; ramReady arrives k cycles into MEM_WAIT.
    // retry: first RELOOK misses again. intr: a second request is held from MEM_WAIT on.
    task automatic run_miss(input logic [14:0] a, input int k, input bit intr, input bit retry);
        logic [14:0] base;
        base = {a[14:2], 2'b00};
        bus.memReadReq = 1'b1; bus.address = a; bus.hit = 1'b0;
        tick;
        bus.memReadReq = intr;
        bus.address    = intr ? 15'h0456 : 15'h0000;
        chk("lk_cread", bus.cRead, 1);
        chk("lk_caddr", bus.cacheAddress, a);
        count_miss();
        tick;
        for (int r = 0; r <= int'(retry); r++) begin
            for (int i = 1; i <= k; i++) begin
                chk("mw_ramread", bus.ramRead, 1);
                chk("mw_ramaddr", bus.ramAddress, base);
                chk("mw_cwrite", bus.cWrite, 0);
                bus.ramReady = (i == k);
                tick;
            end
            bus.ramReady = 1'b0;
            chk("fill_cwrite", bus.cWrite, 1);
            chk("fill_adr0", bus.adr0, base);
            chk("fill_adr1", bus.adr1, base + 15'd1);
            chk("fill_adr2", bus.adr2, base + 15'd2);
            chk("fill_adr3", bus.adr3, base + 15'd3);
            chk("fill_ramread", bus.ramRead, 0);
            bus.hit = (r == int'(retry));
            tick;
            chk("rl_cread", bus.cRead, 1);
            chk("rl_cwrite", bus.cWrite, 0);
            chk("rl_ready", bus.ready, 0);
            tick;
        end
        chk("done_ready", bus.ready, 1);
        chk("done_caddr", bus.cacheAddress, a);
        chk("done_busy", bus.busy, 1);
        bus.hit = 1'b0;
        tick;
        chk("idle_ready", bus.ready, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_caddr", bus.cacheAddress, a);
        chk("idle_miss", bus.missCount, exp_miss);
    endtask

    initial begin
        rst = 1'b1;
        bus.memReadReq = 1'b0; bus.address = '0; bus.hit = 1'b0; bus.ramReady = 1'b0;
        tick; tick;
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_cread", bus.cRead, 0);
        chk("rst_cwrite", bus.cWrite, 0);
        chk("rst_ramread", bus.ramRead, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_caddr", bus.cacheAddress, 0);
        chk("rst_miss", bus.missCount, 0);

        // Hit: ready two cycles after the accepting IDLE cycle.
        bus.memReadReq = 1'b1; bus.address = 15'h0123; bus.hit = 1'b1;
        tick;
        bus.memReadReq = 1'b0;
        chk("hit_lk_busy", bus.busy, 1);
        chk("hit_lk_cread", bus.cRead, 1);
        chk("hit_lk_caddr", bus.cacheAddress, 15'h0123);
        chk("hit_lk_ready", bus.ready, 0);
        tick;
        chk("hit_done_ready", bus.ready, 1);
        chk("hit_done_ramread", bus.ramRead, 0);
        bus.hit = 1'b0;
        tick;
        chk("hit_idle_ready", bus.ready, 0);
        chk("hit_idle_busy", bus.busy, 0);
        chk("hit_miss", bus.missCount, 0);

        // Stray ramReady in IDLE does nothing.
        bus.ramReady = 1'b1;
        tick;
        bus.ramReady = 1'b0;
        chk("stray_busy", bus.busy, 0);
        chk("stray_cwrite", bus.cWrite, 0);

        // Reset while waiting on memory; the late ramReady must be dropped.
        bus.memReadReq = 1'b1; bus.address = 15'h0300; bus.hit = 1'b0;
        tick;
        bus.memReadReq = 1'b0;
        tick;
        chk("rmw_ramread", bus.ramRead, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.ramReady = 1'b1;
        chk("rmw_busy", bus.busy, 0);
        chk("rmw_ramread0", bus.ramRead, 0);
        chk("rmw_miss", bus.missCount, 0);
        chk("rmw_caddr", bus.cacheAddress, 0);
        exp_miss = 0;
        tick;
        bus.ramReady = 1'b0;
        chk("rmw_cwrite", bus.cWrite, 0);
        chk("rmw_busy2", bus.busy, 0);

        // Miss 0x1235, ramReady 3 cycles into MEM_WAIT, 0x0456 presented while busy.
        run_miss(15'h1235, 3, 1'b1, 1'b0);
        chk("m1_ramaddr", bus.ramAddress, 15'h1234);
        chk("m1_adr3", bus.adr3, 15'h1237);
        // 0x0456 is still held and is taken at this IDLE cycle.
        bus.hit = 1'b1;
        tick;
        bus.memReadReq = 1'b0;
        chk("req2_caddr", bus.cacheAddress, 15'h0456);
        chk("req2_cread", bus.cRead, 1);
        tick;
        chk("req2_ready", bus.ready, 1);
        bus.hit = 1'b0;
        tick;
        chk("req2_busy", bus.busy, 0);

        // Block base wraps without carry.
        run_miss(15'h7FFE, 1, 1'b0, 1'b0);
        chk("wrap_ramaddr", bus.ramAddress, 15'h7FFC);
        chk("wrap_adr3", bus.adr3, 15'h7FFF);

        // RELOOK miss retries memory without counting.
        run_miss(15'h0201, 2, 1'b0, 1'b1);
        chk("miss_total", bus.missCount, exp_miss);
`ifdef CACHE_CTRL_MISS_CNT_EN
        chk("miss_total_on", bus.missCount, 3);
`else
        chk("miss_total_off", bus.missCount, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
- REQ-001: Parameter ADDRESSL, default 12, cache index width in bits.
- REQ-002: Parameter TAG, default 3, tag width in bits; address width AW = ADDRESSL+TAG (15).
- REQ-003: Parameter BLOCKL, default 4, words per block; fixed at 4, so the word offset is address[1:0].
- REQ-004: The block SHALL have one clock; reset is synchronous and active-high.
- REQ-005: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-006: rst  input  1  synchronous active-high reset.
- REQ-007: memReadReq  input  1  CPU read request, sampled only in IDLE.
- REQ-008: address  input  AW  CPU word address, captured with the accepted request.
- REQ-009: hit  input  1  cache hit indication for cacheAddress, combinational from the cache.
- REQ-010: cacheAddress  output  AW  address presented to the cache lookup port.
- REQ-011: cRead  output  1  cache read enable.
- REQ-012: cWrite  output  1  cache block-fill write enable.
- REQ-013: adr0, adr1, adr2, adr3  output  AW each  fill addresses for block words 0..3.
- REQ-014: ramRead  output  1  main-memory block read request.
- REQ-015: ramAddress  output  AW  block base address to memory.
- REQ-016: ramReady  input  1  memory block data valid on dataRtoC, one-cycle pulse.
- REQ-017: ready  output  1  one-cycle pulse; cache data for the captured address is valid.
- REQ-018: busy  output  1  high in every state except IDLE.
- REQ-019: missCount  output  15  count of lookup misses.

Function
- REQ-020: The FSM SHALL have the states IDLE, LOOKUP, MEM_WAIT, FILL, RELOOK and DONE, with all outputs registered or decoded from state.
- REQ-021: IDLE: when memReadReq=1, capture address into addrReg and go to LOOKUP; otherwise stay in IDLE.
- REQ-022: LOOKUP and RELOOK: drive cRead=1 and cacheAddress=addrReg; hit=1 goes to DONE; hit=0 goes to MEM_WAIT.
- REQ-023: MEM_WAIT: drive ramRead=1 and ramAddress={addrReg[AW-1:2],2'b00}; hold until ramReady=1, then go to FILL; no timeout.
- REQ-024: FILL: drive cWrite=1 for exactly one cycle with adrN={addrReg[AW-1:2],N}, then go to RELOOK.
- REQ-025: RELOOK with hit=0 SHALL return to MEM_WAIT, i.e. retry; it does not count as a miss.
- REQ-026: DONE: drive ready=1 and cRead=1 with cacheAddress=addrReg for one cycle, then go to IDLE.
- REQ-027: Latency: hit gives ready 2 cycles after request acceptance; miss with ramReady k cycles into MEM_WAIT gives ready k+4 cycles after acceptance.
- REQ-028: memReadReq and address SHALL be ignored outside IDLE; a request present in the DONE cycle is not accepted until the following IDLE cycle.
- REQ-029: ramReady outside MEM_WAIT SHALL be ignored.
- REQ-030: Block address arithmetic SHALL wrap without carry: base 0x7FFC gives adr3=0x7FFF.
- REQ-031: In inactive states, cRead, cWrite, ramRead and ready SHALL be 0; cacheAddress, ramAddress and adr0..3 SHALL hold addrReg-derived values.

Reset
- REQ-032: rst=1 at a clock edge SHALL force IDLE, addrReg=0, missCount=0, and cRead=cWrite=ramRead=ready=busy=0, from any state including MEM_WAIT and FILL.
- REQ-033: A ramReady arriving after reset aborts MEM_WAIT SHALL be ignored.

Configuration
- REQ-034: With CACHE_CTRL_MISS_CNT_EN defined, missCount SHALL increment by 1 on each LOOKUP with hit=0 and wrap from 0x7FFF to 0.
- REQ-035: With CACHE_CTRL_MISS_CNT_EN undefined, missCount SHALL be constant 0 and no counter register is synthesized.

Verification
- REQ-036: Hit: req 0x0123, hit=1 in LOOKUP -> ready=1 exactly 2 cycles after acceptance; ramRead never asserted; missCount unchanged.
- REQ-037: Miss: req 0x1235, hit=0, ramReady 3 cycles into MEM_WAIT -> ramAddress=0x1234; cWrite one cycle with adr0..3=0x1234..0x1237; ready at cycle 7; missCount +1 (macro on).
- REQ-038: Wrap: req 0x7FFE miss -> ramAddress=0x7FFC, adr3=0x7FFF.
- REQ-039: Reset in MEM_WAIT: rst pulse, then ramReady=1 -> no cWrite, state IDLE, busy=0, missCount=0.
- REQ-040: Busy ignore: second memReadReq with address 0x0456 during MEM_WAIT -> completion serves the first address only; 0x0456 is served only after it is re-presented in IDLE.
- REQ-041: Macro off: 3 misses -> missCount stays 0; macro on -> missCount=3.
